// File: rtl/memory_ws_if.sv
// Control/status handshake between the CPU control unit and memory_ws.
// The shared data bus itself is a plain inout port on the memory block.
interface memory_ws_if;
  logic       MAin;
  logic       MDbus;
  logic       MDout;
  logic       read;
  logic       write;
  logic [1:0] size;
  logic       uns;
  logic       Wait;
  logic       err;

  modport master (output MAin, MDbus, MDout, read, write, size, uns,
                  input  Wait, err);
  modport slave  (input  MAin, MDbus, MDout, read, write, size, uns,
                  output Wait, err);
endinterface

// File: rtl/memory_ws.sv
// Bus-attached data memory with MA/MD registers, byte/half/word access,
// a configurable number of wait states and request error flagging.
module memory_ws #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic           clk,
  input  logic           rst,
  inout  wire  [W-1:0]   bus,
  memory_ws_if.slave     cpu
);
  localparam int NB = W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [W-1:0] merge_lanes(input logic [W-1:0]  old,
                                               input logic [W-1:0]  md,
                                               input logic [1:0]    sz,
                                               input logic [LB-1:0] lane);
    logic [W-1:0] w;
    w = old;
    case (sz)
      2'b00:   w[8*lane +: 8]  = md[7:0];
      2'b01:   w[8*lane +: 16] = md[15:0];
      default: w = md;
    endcase
    return w;
  endfunction

  function automatic logic [W-1:0] extract(input logic [W-1:0]  word,
                                           input logic [1:0]    sz,
                                           input logic          uns,
                                           input logic [LB-1:0] lane);
    logic [W-1:0]       sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic [W-1:0]       r;
    sh  = word >> (8*lane);
    b8  = sh[7:0];
    h16 = sh[15:0];
    case (sz)
      2'b00: begin
        if (uns) r = W'(sh[7:0]);
        else     r = W'(b8);
      end
      2'b01: begin
        if (uns) r = W'(sh[15:0]);
        else     r = W'(h16);
      end
      default: r = word;
    endcase
    return r;
  endfunction

  logic [W-1:0]  mem [DEPTH];

  state_t        state_q;
  logic [W-1:0]  ma_q, md_q;
  logic [CW-1:0] cnt_q;
  logic          wait_q, err_q;
  logic          op_wr_q, uns_q;
  logic [1:0]    size_q;
  logic [AW-1:0] idx_q;
  logic [LB-1:0] lane_q;

  logic          req, bad, oor, mis, accept;
  logic          ex_go, ex_wr, ex_uns, mem_we;
  logic [1:0]    ex_size;
  logic [AW-1:0] ex_idx;
  logic [LB-1:0] ex_lane;
  logic [W-1:0]  ex_word, rd_val, wr_val;

  assign bus     = cpu.MDout ? md_q : 'z;
  assign cpu.Wait = wait_q;
  assign cpu.err  = err_q;

  always_comb begin
    req    = (state_q == IDLE) && (cpu.read || cpu.write);
    oor    = (ma_q >> (LB + AW)) != '0;
    mis    = ((cpu.size == 2'b01) && ma_q[0]) ||
             ((cpu.size == 2'b10) && (ma_q[LB-1:0] != '0));
    bad    = (cpu.read && cpu.write) || (cpu.size == 2'b11) || oor || mis;
    accept = req && !bad;
    // Zero-wait executes straight from the live request; otherwise from latched operands
    if (LAT == 0) begin
      ex_go   = accept;
      ex_wr   = cpu.write;
      ex_size = cpu.size;
      ex_uns  = cpu.uns;
      ex_idx  = ma_q[LB+AW-1:LB];
      ex_lane = ma_q[LB-1:0];
    end else begin
      ex_go   = (state_q == BUSY) && (cnt_q == CW'(1));
      ex_wr   = op_wr_q;
      ex_size = size_q;
      ex_uns  = uns_q;
      ex_idx  = idx_q;
      ex_lane = lane_q;
    end
    ex_word = mem[ex_idx];
    rd_val  = extract(ex_word, ex_size, ex_uns, ex_lane);
    wr_val  = merge_lanes(ex_word, md_q, ex_size, ex_lane);
    mem_we  = ex_go && ex_wr && rst;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[ex_idx] <= wr_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
      op_wr_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      idx_q   <= '0;
      lane_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu.MAin)  ma_q <= bus;
          if (cpu.MDbus) md_q <= bus;
          if (req) begin
            if (bad) begin
              err_q <= 1'b1;
            end else begin
              err_q <= 1'b0;
              if (LAT == 0) begin
                if (!cpu.write) md_q <= rd_val;
              end else begin
                state_q <= BUSY;
                cnt_q   <= CW'(LAT);
                wait_q  <= 1'b1;
                op_wr_q <= cpu.write;
                size_q  <= cpu.size;
                uns_q   <= cpu.uns;
                idx_q   <= ma_q[LB+AW-1:LB];
                lane_q  <= ma_q[LB-1:0];
              end
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            if (!op_wr_q) md_q <= rd_val;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_ws.sv
// Bench for memory_ws: directed scenarios plus randomized transactions
// checked against a byte-addressed reference memory model.
module tb_memory_ws;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] drv0 = '0, drv1 = '0;
  logic        drv_en0 = 1'b0, drv_en1 = 1'b0;
  wire  [31:0] bus0, bus1;
  int          vectors = 0;
  int          fails = 0;
  int          w1_hi = 0;
  logic [31:0] mref [256];
  logic [31:0] last_md;

  memory_ws_if if0();
  memory_ws_if if1();

  assign bus0 = drv_en0 ? drv0 : 'z;
  assign bus1 = drv_en1 ? drv1 : 'z;

  memory_ws #(.W(32), .DEPTH(256), .LAT(2)) u_dut0 (.clk(clk), .rst(rst_n), .bus(bus0), .cpu(if0));
  memory_ws #(.W(32), .DEPTH(256), .LAT(0)) u_dut1 (.clk(clk), .rst(rst_n), .bus(bus1), .cpu(if1));

  always #5 clk = ~clk;

  always @(negedge clk) if (if1.Wait === 1'b1) w1_hi++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed little-endian memory with plain arithmetic
  function automatic bit m_err(input logic [31:0] a, input bit rd, input bit wr, input logic [1:0] sz);
    return (rd && wr) || (sz == 2'd3) || (a >= 32'd1024) ||
           (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz, input bit un);
    logic [31:0] w, v;
    int sh;
    w  = mref[a / 4];
    sh = 8 * int'(a % 4);
    case (sz)
      2'd0: begin v = (w >> sh) & 32'hFF;   if (!un && v >= 32'd128)   v = v + 32'hFFFFFF00; end
      2'd1: begin v = (w >> sh) & 32'hFFFF; if (!un && v >= 32'd32768) v = v + 32'hFFFF0000; end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    sh = 8 * int'(a % 4);
    case (sz)
      2'd0:    mask = 32'hFF << sh;
      2'd1:    mask = 32'hFFFF << sh;
      default: mask = 32'hFFFFFFFF;
    endcase
    mref[a / 4] = (mref[a / 4] & ~mask) | ((d << sh) & mask);
  endtask

  task automatic load_ma(input logic [31:0] v);
    drv0 = v; drv_en0 = 1'b1; if0.MAin = 1'b1;
    step();
    if0.MAin = 1'b0; drv_en0 = 1'b0;
  endtask

  task automatic load_md(input logic [31:0] v);
    drv0 = v; drv_en0 = 1'b1; if0.MDbus = 1'b1;
    step();
    if0.MDbus = 1'b0; drv_en0 = 1'b0;
  endtask

  task automatic read_md(output logic [31:0] v);
    drv_en0 = 1'b0; if0.MDout = 1'b1;
    #1 v = bus0;
    if0.MDout = 1'b0;
    #1;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit un,
                        output int nw, output logic e);
    if0.read = rd; if0.write = wr; if0.size = sz; if0.uns = un;
    step();
    if0.read = 1'b0; if0.write = 1'b0;
    e  = if0.err;
    nw = 0;
    while (if0.Wait && nw < 20) begin nw++; step(); end
  endtask

  task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input bit rd, input bit wr, input logic [1:0] sz, input bit un);
    int nw;
    logic e;
    bit exp_e;
    logic [31:0] exp_md;
    load_ma(a);
    load_md(d);
    exp_e  = m_err(a, rd, wr, sz);
    exp_md = d;
    if (!exp_e && rd) exp_md = m_read(a, sz, un);
    access(rd, wr, sz, un, nw, e);
    if (!exp_e && wr) m_write(a, d, sz);
    check({tag, ":err"}, 32'(e), 32'(exp_e));
    check({tag, ":wait"}, nw, exp_e ? 32'd0 : 32'd2);
    read_md(last_md);
    check({tag, ":md"}, last_md, exp_md);
  endtask

  initial begin
    int nw;
    logic e;
    logic [31:0] v;
    if0.MAin = 0; if0.MDbus = 0; if0.MDout = 0; if0.read = 0; if0.write = 0; if0.size = 0; if0.uns = 0;
    if1.MAin = 0; if1.MDbus = 0; if1.MDout = 0; if1.read = 0; if1.write = 0; if1.size = 0; if1.uns = 0;
    for (int i = 0; i < 256; i++) mref[i] = '0;

    step(); step();
    rst_n = 1'b1;
    check("rst:wait", 32'(if0.Wait), 32'd0);
    check("rst:err", 32'(if0.err), 32'd0);
    read_md(v);
    check("rst:md", v, 32'd0);
    check("rst1:wait", 32'(if1.Wait), 32'd0);

    // Word write/read and bus drive/release
    xact("t1_wr", 32'd4, 32'hDEADBEEF, 0, 1, 2'd2, 0);
    xact("t1_rd", 32'd4, 32'h0, 1, 0, 2'd2, 0);
    check("t1_lit", last_md, 32'hDEADBEEF);
    drv0 = 32'h0; drv_en0 = 1'b1;
    #1 check("t1_release", bus0, 32'h0);
    drv_en0 = 1'b0;

    // Sub-word reads with sign/zero extension
    xact("t2a", 32'd7, 32'h0, 1, 0, 2'd0, 0); check("t2a_lit", last_md, 32'hFFFFFFDE);
    xact("t2b", 32'd7, 32'h0, 1, 0, 2'd0, 1); check("t2b_lit", last_md, 32'h000000DE);
    xact("t2c", 32'd6, 32'h0, 1, 0, 2'd1, 0); check("t2c_lit", last_md, 32'hFFFFDEAD);
    xact("t2d", 32'd4, 32'h0, 1, 0, 2'd1, 1); check("t2d_lit", last_md, 32'h0000BEEF);

    xact("t3_wr", 32'd5, 32'h00000012, 0, 1, 2'd0, 0);
    xact("t3_rd", 32'd4, 32'h0, 1, 0, 2'd2, 0); check("t3_lit", last_md, 32'hDEAD12EF);

    // Rejected requests
    xact("t4_misw", 32'd6, 32'h77, 1, 0, 2'd2, 0);
    xact("t4_mish", 32'd5, 32'h78, 0, 1, 2'd1, 0);
    xact("t4_oor", 32'h400, 32'h79, 1, 0, 2'd2, 0);
    xact("t4_both", 32'd4, 32'h7A, 1, 1, 2'd2, 0);
    xact("t4_sz3", 32'd4, 32'h7B, 0, 1, 2'd3, 0);
    xact("t4_clr", 32'd4, 32'h0, 1, 0, 2'd2, 0); check("t4_lit", last_md, 32'hDEAD12EF);

    // Simultaneous MA/MD load of one bus value
    drv0 = 32'h20; drv_en0 = 1'b1; if0.MAin = 1'b1; if0.MDbus = 1'b1;
    step();
    if0.MAin = 1'b0; if0.MDbus = 1'b0; drv_en0 = 1'b0;
    read_md(v);
    check("both_ld", v, 32'h20);

    xact("t5_p8", 32'd8, 32'h11111111, 0, 1, 2'd2, 0);
    xact("t5_p20", 32'h20, 32'hA5A5A5A5, 0, 1, 2'd2, 0);
    xact("t5_p0", 32'd0, 32'h0BADF00D, 0, 1, 2'd2, 0);

    // Operand changes and repeated requests while busy are ignored
    load_ma(32'd4);
    load_md(32'h0);
    if0.read = 1'b1; if0.size = 2'd2; if0.uns = 1'b0;
    step();
    check("t5_w0", 32'(if0.Wait), 32'd1);
    if0.MAin = 1'b1; drv0 = 32'd8; drv_en0 = 1'b1;
    step();
    check("t5_w1", 32'(if0.Wait), 32'd1);
    if0.MAin = 1'b0; if0.MDbus = 1'b1; drv0 = 32'h55;
    step();
    if0.MDbus = 1'b0; if0.read = 1'b0; drv_en0 = 1'b0;
    check("t5_w2", 32'(if0.Wait), 32'd0);
    read_md(v);
    check("t5_md", v, 32'hDEAD12EF);
    access(1, 0, 2'd2, 0, nw, e);
    check("t5_again_wait", nw, 32'd2);
    read_md(v);
    check("t5_ma_kept", v, 32'hDEAD12EF);

    // Reset in the middle of a write aborts it
    load_ma(32'h20);
    load_md(32'h12345678);
    if0.write = 1'b1; if0.size = 2'd2;
    step();
    if0.write = 1'b0;
    check("t5r_busy", 32'(if0.Wait), 32'd1);
    rst_n = 1'b0;
    #1 check("t5r_wait", 32'(if0.Wait), 32'd0);
    read_md(v);
    check("t5r_md", v, 32'd0);
    step(); step();
    rst_n = 1'b1;
    access(1, 0, 2'd2, 0, nw, e);
    read_md(v);
    check("t5r_ma0", v, 32'h0BADF00D);
    xact("t5r_w8", 32'h20, 32'h0, 1, 0, 2'd2, 0);
    check("t5r_lit", last_md, 32'hA5A5A5A5);

    // Zero-wait instance
    drv1 = 32'hC; drv_en1 = 1'b1; if1.MAin = 1'b1; step(); if1.MAin = 1'b0;
    drv1 = 32'hCAFEF00D; if1.MDbus = 1'b1; step(); if1.MDbus = 1'b0; drv_en1 = 1'b0;
    if1.write = 1'b1; if1.size = 2'd2; step(); if1.write = 1'b0;
    check("t6_wr_err", 32'(if1.err), 32'd0);
    drv1 = 32'h0; drv_en1 = 1'b1; if1.MDbus = 1'b1; step(); if1.MDbus = 1'b0; drv_en1 = 1'b0;
    if1.read = 1'b1; step(); if1.read = 1'b0;
    if1.MDout = 1'b1;
    #1 check("t6_md", bus1, 32'hCAFEF00D);
    if1.MDout = 1'b0;
    check("t6_rd_err", 32'(if1.err), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) xact("rnd_init", 32'(4 * i), $urandom, 0, 1, 2'd2, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int op;
      a  = ($urandom_range(0, 9) == 0) ? (32'h400 + $urandom_range(0, 255)) : 32'($urandom_range(0, 63));
      op = $urandom_range(0, 7);
      xact("rnd", a, $urandom, (op == 0) || (op >= 4), (op <= 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("t6_wait_never", w1_hi, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/memory_ws.md
Name: memory_ws

Overview:
- Parametrised wait-state successor to the CPU's bus-attached data memory.
- Sits on the shared tri-state CPU bus. Holds its own memory-address register (MA) and memory-data register (MD), both loaded from the bus.
- Runs word, halfword and byte reads and writes. Each access has a configurable number of wait states, reported to the control unit through Wait.
- Flags misaligned, out-of-range and conflicting requests.

Parameters:
W, 32, data/bus width in bits; multiple of 8, at least 16; NB=W/8 byte lanes, LB=$clog2(NB)
DEPTH, 256, number of W-bit words; AW=$clog2(DEPTH)
LAT, 2, wait states per access; 0 = zero-wait

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
bus  inout  W  shared CPU bus
MAin  in  1  load MA from bus
MDbus  in  1  load MD from bus
MDout  in  1  drive MD onto bus
read  in  1  request read of mem[MA] into MD
write  in  1  request write of MD to mem[MA]
size  in  2  access size: 00 byte, 01 half, 10 full word, 11 reserved (treated as error)
uns  in  1  loads: 1 zero-extend, 0 sign-extend
Wait  out  1  access in progress
err  out  1  last request rejected

Behaviour:
- Reset (rst=0, async):
  - MA=0, MD=0, state=IDLE, count=0, Wait=0, err=0.
  - Memory array is not cleared.
  - Reset during BUSY aborts the access; no array write occurs.
- Bus drive:
  - bus = MDout ? MD : 'z, combinational.
  - The block never drives the bus otherwise. MDout is honoured in any state.
- Register loads, at posedge, in IDLE only:
  - MAin: MA<=bus. MDbus: MD<=bus.
  - If both are high, both load the same bus value.
  - Ignored in BUSY, so operands stay stable.
- Addressing:
  - MA is a byte address, little-endian.
  - Word index = MA[LB+AW-1:LB]; lane = MA[LB-1:0].
- A request (read or write high at posedge in IDLE) is rejected with err<=1 when any of these holds:
  - read and write are both high.
  - size=11.
  - Out of range: any MA bit at or above LB+AW is set.
  - Misaligned: half with MA[0]=1, or word with MA[LB-1:0]≠0.
  - On rejection: no access, MD unchanged, Wait stays 0, state stays IDLE.
- An accepted request sets err<=0.
- State machine, IDLE/BUSY:
  - LAT=0: an accepted request executes at the sampling edge N. Wait never rises.
  - LAT>0: at edge N the block latches the operation, size, uns, word index and lane. state<=BUSY, count<=LAT, Wait<=1.
  - Each BUSY edge decrements count. At the edge where count==1 the access executes, state<=IDLE, Wait<=0.
  - Wait is therefore high for exactly LAT cycles (edges N+1..N+LAT).
  - MD holds the result after edge N+LAT; the first MDout use is in the following cycle.
  - read/write during BUSY are ignored, not queued.
- Write execution, byte-enable merge into the addressed word; other lanes are preserved:
  - byte: MD[7:0] into the lane.
  - half: MD[15:0] into lanes lane, lane+1.
  - word: full MD.
- Read execution: MD <= the selected byte/half/word, right-aligned, then extended per uns to W bits. A word read ignores uns.
- Single synchronous array port; at most one access per cycle by construction.

Test Plan (W=32, DEPTH=256, LAT=2 unless stated):
1. Hold rst=0 two cycles, then release.
   - Word write: MAin with bus=4; MDbus with bus=0xDEADBEEF; write with size=10.
   - Required: Wait high exactly 2 cycles, err=0.
   - Read back MA=4, word → MD=0xDEADBEEF; bus shows 0xDEADBEEF while MDout=1 and is Z otherwise.
2. Byte and half reads on word 4:
   - MA=7 byte uns=0 → 0xFFFFFFDE; uns=1 → 0x000000DE.
   - MA=6 half uns=0 → 0xFFFFDEAD.
   - MA=4 half uns=1 → 0x0000BEEF.
3. Byte write MA=5, MD=0x00000012, size=00 → word read at 4 returns 0xDEAD12EF.
4. Each of the following → err=1, Wait stays 0, MD and memory unchanged:
   - MA=6 with size=10.
   - MA=5 with size=01.
   - MA=0x400 (out of range).
   - read and write high together.
   - size=11.
   - The next valid request then clears err.
5. During BUSY:
   - Assert read again, pulse MAin with bus=8 and MDbus with bus=0x55: all are ignored. Only one access occurs, and MA/MD reflect the original operands plus the result.
   - Pull rst low mid-write to word 8: Wait=0, MA=MD=0, word 8 unchanged on a later read.
6. Instance with LAT=0: a write then a read to MA=0xC complete in one cycle each, Wait never asserts, and MD=0xCAFEF00D on the cycle after the read edge.
